// File: rtl/seg7_bcd_encoder_if.sv
// ---------------------------------------------------------------------------
// seg7_bcd_encoder_if
// Value handshake and display-word bundle for seg7_bcd_encoder.
//   in_valid  : producer offers in_value
//   in_ready  : encoder can accept a value
//   in_value  : 7-bit unsigned binary, 0..127
//   both7seg  : {tens[6:0], ones[6:0]}, bit0 = segment a .. bit6 = segment g
//   out_valid : one-cycle pulse, both7seg has just been updated
//   busy      : conversion in progress (inverse of in_ready)
// Modports: master = value producer, slave = encoder.
// ---------------------------------------------------------------------------
interface seg7_bcd_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_value;
  logic [13:0] both7seg;
  logic        out_valid;
  logic        busy;

  modport master (
    output in_valid, in_value,
    input  in_ready, both7seg, out_valid, busy
  );

  modport slave (
    input  in_valid, in_value,
    output in_ready, both7seg, out_valid, busy
  );
endinterface

// File: rtl/seg7_bcd_encoder.sv
// ---------------------------------------------------------------------------
// seg7_bcd_encoder
// Converts a 7-bit binary value into two seven-segment digit patterns using a
// sequential double-dabble (7 shift cycles) followed by one decode cycle.
// The display word is held stable between updates.
//
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : seg7_bcd_encoder_if.slave (in_valid/in_ready/in_value handshake,
//          both7seg, out_valid, busy)
// Parameters:
//   SEG_ACTIVE_LOW : 1 inverts all 14 segment bits (reset value and blanks too)
// Build option:
//   SEG7_LEADING_ZERO_BLANK_EN : blank the tens digit when it is 0 and the
//                                value is not an overflow
// ---------------------------------------------------------------------------
module seg7_bcd_encoder #(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  seg7_bcd_encoder_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DECODE} state_t;

  localparam logic [13:0] INV_MASK = {14{SEG_ACTIVE_LOW}};
  localparam logic [6:0]  SEG_DASH = 7'h40;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [13:0] RESET_SEG = {7'h00, 7'h3F};
`else
  localparam logic [13:0] RESET_SEG = {7'h3F, 7'h3F};
`endif

  state_t      state;
  logic [6:0]  shift_reg;
  logic [7:0]  bcd_reg;     // [7:4] tens, [3:0] ones
  logic        ovf_reg;
  logic [2:0]  cnt_reg;
  logic [13:0] seg_reg;     // stored already polarity-adjusted
  logic        out_valid_reg;
  logic        ready_reg;

  logic [7:0]  bcd_adj;
  logic [14:0] dd_next;
  logic [6:0]  tens_seg;
  logic [6:0]  ones_seg;
  logic [13:0] seg_dec;

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd0:    digit_seg = 7'h3F;
      4'd1:    digit_seg = 7'h06;
      4'd2:    digit_seg = 7'h5B;
      4'd3:    digit_seg = 7'h4F;
      4'd4:    digit_seg = 7'h66;
      4'd5:    digit_seg = 7'h6D;
      4'd6:    digit_seg = 7'h7D;
      4'd7:    digit_seg = 7'h07;
      4'd8:    digit_seg = 7'h7F;
      4'd9:    digit_seg = 7'h6F;
      default: digit_seg = 7'h00;  // only reachable for overflow values, masked by ovf
    endcase
  endfunction

  // One double-dabble step: add-3 correction on each nibble, then shift
  // {bcd, binary} left by one. Tens may exceed 9 for inputs above 99; that
  // result is never displayed because ovf forces dashes.
  always_comb begin
    bcd_adj[7:4] = (bcd_reg[7:4] >= 4'd5) ? bcd_reg[7:4] + 4'd3 : bcd_reg[7:4];
    bcd_adj[3:0] = (bcd_reg[3:0] >= 4'd5) ? bcd_reg[3:0] + 4'd3 : bcd_reg[3:0];
    dd_next      = {bcd_adj, shift_reg} << 1;
  end

  always_comb begin
    tens_seg = digit_seg(bcd_reg[7:4]);
    ones_seg = digit_seg(bcd_reg[3:0]);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (bcd_reg[7:4] == 4'd0) begin
      tens_seg = 7'h00;
    end
`endif
    if (ovf_reg) begin
      seg_dec = {SEG_DASH, SEG_DASH};
    end else begin
      seg_dec = {tens_seg, ones_seg};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      shift_reg     <= '0;
      bcd_reg       <= '0;
      ovf_reg       <= 1'b0;
      cnt_reg       <= '0;
      seg_reg       <= RESET_SEG ^ INV_MASK;
      out_valid_reg <= 1'b0;
      ready_reg     <= 1'b1;
    end else begin
      out_valid_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid && ready_reg) begin
            shift_reg <= bus.in_value;
            bcd_reg   <= '0;
            ovf_reg   <= (bus.in_value > 7'd99);
            cnt_reg   <= 3'd7;
            ready_reg <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_reg   <= dd_next[14:7];
          shift_reg <= dd_next[6:0];
          cnt_reg   <= cnt_reg - 3'd1;
          // cnt_reg == 1 means this edge performs the 7th shift
          if (cnt_reg == 3'd1) begin
            state <= DECODE;
          end
        end
        DECODE: begin
          seg_reg       <= seg_dec ^ INV_MASK;
          out_valid_reg <= 1'b1;
          ready_reg     <= 1'b1;
          state         <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = ready_reg;
  assign bus.busy      = !ready_reg;
  assign bus.both7seg  = seg_reg;
  assign bus.out_valid = out_valid_reg;

endmodule

// File: tb/tb_seg7_bcd_encoder.sv
module tb_seg7_bcd_encoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg7_bcd_encoder_if bus_h();
  seg7_bcd_encoder_if bus_l();

  seg7_bcd_encoder #(.SEG_ACTIVE_LOW(1'b0)) dut_h (.clk(clk), .rst(rst), .bus(bus_h));
  seg7_bcd_encoder #(.SEG_ACTIVE_LOW(1'b1)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [6:0]  seg_tbl [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [13:0] shown;  // active-high word the display should currently hold

  // Reference: decimal digits by division, table lookup, dashes above 99.
  function automatic logic [13:0] model(input int v);
    int         tens;
    int         ones;
    logic [6:0] t;
    tens = v / 10;
    ones = v % 10;
    if (v > 99) return {7'h40, 7'h40};
    t = seg_tbl[tens];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (tens == 0) t = 7'h00;
`endif
    return {t, seg_tbl[ones]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_seg(input string tag, input logic [13:0] exp);
    chk(tag, {18'd0, bus_h.both7seg}, {18'd0, exp});
    chk({tag, "_al"}, {18'd0, bus_l.both7seg}, {18'd0, ~exp});
  endtask

  task automatic drive(input logic [6:0] v, input logic valid);
    bus_h.in_valid = valid;
    bus_l.in_valid = valid;
    bus_h.in_value = v;
    bus_l.in_value = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Handshake v at E0, then walk E1..E8 checking hold, ready and pulse timing.
  // hold=1 keeps in_valid high with junk data during the conversion.
  task automatic do_conv(input logic [6:0] v, input bit hold);
    logic [13:0] e;
    e = model(int'(v));
    chk("ready_before", {31'd0, bus_h.in_ready}, 32'd1);
    drive(v, 1'b1);
    step();
    chk("ready_fall", {31'd0, bus_h.in_ready}, 32'd0);
    chk("busy_high", {31'd0, bus_h.busy}, 32'd1);
    drive(7'($urandom_range(0, 127)), hold ? 1'b1 : 1'b0);
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k < 8) begin
        chk("ovalid_early", {31'd0, bus_h.out_valid}, 32'd0);
        chk("ready_low", {31'd0, bus_h.in_ready}, 32'd0);
        chk_seg("seg_hold", shown);
      end else begin
        chk("ovalid_pulse", {31'd0, bus_h.out_valid}, 32'd1);
        chk("ovalid_pulse_al", {31'd0, bus_l.out_valid}, 32'd1);
        chk("ready_rise", {31'd0, bus_h.in_ready}, 32'd1);
        chk_seg("seg_value", e);
        shown = e;
      end
    end
    $display("conv in=%0d both7seg=0x%04h expected=0x%04h", v, bus_h.both7seg, e);
  endtask

  task automatic chk_clear();
    step();
    chk("ovalid_clear", {31'd0, bus_h.out_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(7'd0, 1'b0);
    step();
    step();
    shown = model(0);
    chk_seg("reset_seg", shown);
    chk("reset_ready", {31'd0, bus_h.in_ready}, 32'd1);
    chk("reset_ovalid", {31'd0, bus_h.out_valid}, 32'd0);
    chk("reset_busy", {31'd0, bus_h.busy}, 32'd0);
    rst = 1'b0;
    step();
    chk_seg("idle_seg", shown);
    $display("reset both7seg=0x%04h", bus_h.both7seg);

    do_conv(7'd42, 1'b0);  chk_clear();
    do_conv(7'd99, 1'b0);  chk_clear();
    do_conv(7'd100, 1'b0); chk_clear();
    do_conv(7'd127, 1'b0); chk_clear();
    do_conv(7'd7, 1'b0);   chk_clear();
    do_conv(7'd0, 1'b0);   chk_clear();

    // Back-to-back stream with in_valid held: handshakes at E0, E9, E18
    do_conv(7'd1, 1'b1);
    do_conv(7'd2, 1'b1);
    do_conv(7'd3, 1'b0);
    chk_clear();

    // Reset at E4 of a conversion of 55
    drive(7'd55, 1'b1);
    step();
    drive(7'd0, 1'b0);
    step(); step(); step();
    rst = 1'b1;
    step();
    shown = model(0);
    chk_seg("abort_seg", shown);
    chk("abort_ovalid", {31'd0, bus_h.out_valid}, 32'd0);
    chk("abort_ready", {31'd0, bus_h.in_ready}, 32'd1);
    // Reset wins over a simultaneous handshake
    drive(7'd12, 1'b1);
    step();
    chk("rst_prio_ready", {31'd0, bus_h.in_ready}, 32'd1);
    rst = 1'b0;
    drive(7'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("no_pulse_after_abort", {31'd0, bus_h.out_valid}, 32'd0);
    end
    chk_seg("abort_seg_held", shown);
    $display("abort reset both7seg=0x%04h", bus_h.both7seg);
    do_conv(7'd12, 1'b0);  chk_clear();

    for (int i = 0; i < 20; i++) begin
      do_conv(7'($urandom_range(0, 127)), 1'b0);
      chk_clear();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg7_bcd_encoder.md
# seg7_bcd_encoder

Converts a 7-bit binary value into two decoded seven-segment digit patterns and presents them as the 14-bit `both7seg` word consumed by the two-digit display multiplexer. It sits directly upstream of that multiplexer. Each accepted value goes through a sequential double-dabble binary-to-BCD conversion, then a BCD-to-segment decode. The output is held stable between updates, so the multiplexer can sample it at any refresh tick.

## Interface
Parameters:
- `SEG_ACTIVE_LOW`, default 0: when 1, all 14 output segment bits are inverted, including the reset value and blanks.

Ports:
- `clk`, input, 1 bit: clock.
- `rst`, input, 1 bit: reset, synchronous, active-high; clock `clk`.
- `in_valid`, input, 1 bit: `in_value` is offered.
- `in_ready`, output, 1 bit: block can accept a value.
- `in_value`, input, 7 bits: unsigned binary, 0..127.
- `both7seg`, output, 14 bits: [13:7] tens digit, [6:0] ones digit. Within each digit, bit0 = a … bit6 = g.
- `out_valid`, output, 1 bit: one-cycle pulse; `both7seg` was just updated.
- `busy`, output, 1 bit: conversion in progress (equals `!in_ready`).

## Operation
- Three states: IDLE, SHIFT, DECODE.
- **IDLE**
  - `in_ready` = 1.
  - On a rising edge where `in_valid && in_ready` (handshake):
    - latch `in_value` into the shift register;
    - clear the 8-bit BCD accumulator (tens[7:4], ones[3:0]);
    - set `ovf = (in_value > 99)`;
    - load the iteration counter with 7;
    - go to SHIFT.
- **SHIFT**
  - Each edge: every BCD nibble ≥ 5 gets +3 (the tens nibble is checked too), then {BCD, shift} is shifted left by 1 and the counter is decremented.
  - After the 7th shift, go to DECODE.
  - `in_valid` is ignored; `in_ready` = 0.
- **DECODE**
  - One edge: register `both7seg`, pulse `out_valid`, return to IDLE.
- Decode table (hex, active-high): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Overflow: if `ovf` = 1, both digits show dash (40), i.e. `both7seg` = {40,40}. The shift sequence still runs, so latency is the same.
- Input values 100..127 never produce a BCD tens digit above 9 on the output path, because `ovf` overrides the decode.
- `both7seg` changes only on the DECODE edge or on reset. It never glitches mid-conversion.

## Timing
- Handshake at edge E0 → SHIFT edges E1..E7 → DECODE edge E8.
- `both7seg` takes its new value and `out_valid` = 1 during the cycle after E8. `out_valid` is cleared at E9.
- Latency is always 8 edges from handshake to update.
- `in_ready` falls after E0 and rises after E8. Earliest next handshake is at E9. Throughput is 1 value per 9 cycles.
- Back-to-back: if `in_valid` is held high, the next value is accepted at E9.
- Reset values (before `SEG_ACTIVE_LOW` inversion):
  - `both7seg` = {3F,3F} ("00");
  - `out_valid` = 0, `in_ready` = 1, `busy` = 0;
  - state IDLE; counter, shift register and `ovf` cleared.
- Reset mid-conversion aborts it. `both7seg` returns to its reset value and no `out_valid` pulse is produced.
- `rst` takes priority over a simultaneous handshake: the value is not accepted.

## Configuration
- Macro: `SEG7_LEADING_ZERO_BLANK_EN`.
- Defined:
  - when the tens BCD digit is 0 and `ovf` = 0, `both7seg[13:7]` = 00 (blank);
  - reset value is {00,3F}.
- Undefined:
  - the tens digit is always decoded (0 → 3F);
  - reset value is {3F,3F}.
- Ones digit and overflow dashes are unaffected either way.

## Test plan
- Reset, no input → `both7seg` = 0x1FBF ({3F,3F}), `in_ready` = 1, `out_valid` = 0. With macro: {00,3F}.
- Handshake with `in_value` = 42 → `out_valid` pulse exactly 8 edges later, `both7seg` = {66,5B}, `in_ready` low for exactly 8 cycles.
- Inputs 99, 100, 127 → 99 gives {6F,6F}; 100 and 127 give {40,40}.
- Input 7 → {3F,07} without macro, {00,07} with it. Input 0 with macro → {00,3F}. Repeat with `SEG_ACTIVE_LOW` = 1: every bit is inverted.
- `in_valid` held high with a value stream 1, 2, 3 → handshakes at E0, E9, E18. Values presented during SHIFT are not captured.
- Assert `rst` at E4 of a conversion of 55 → no `out_valid`, `both7seg` = reset value. The next input 12 converts normally to {06,5B}.
